pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage of the 8-bit MIPS datapath; consumes the 8-bit target produced by the jump-address block and the branch decision from decode/ALU.
- Holds the architectural PC and selects the next PC: increment, branch, jump or hold.
- Inserts flush bubbles after any redirect, supports jump-and-link capture, and halts.
- Drives the instruction-memory address and a fetch-valid qualifier.

Parameters:
- PC_W, 8, PC and address width.
- RESET_PC, 8'h00, PC value loaded on reset.
- FLUSH_CYCLES, 1, bubble cycles after a taken redirect (range 1-3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC and state this cycle.
- jump_en  input  1  take jump this cycle.
- jump_addr  input  PC_W  absolute target from the jump-address block.
- link_en  input  1  with jump_en: capture return address.
- branch_en  input  1  branch condition true this cycle.
- branch_off  input  PC_W  signed word offset, two's complement.
- halt  input  1  enter HALT, sticky.
- pc  output  PC_W  current fetch address.
- pc_plus1  output  PC_W  pc+1 modulo 2^PC_W, combinational.
- fetch_valid  output  1  instruction at pc is to be issued.
- link_addr  output  PC_W  captured return address.
- state  output  2  0=RUN, 1=FLUSH, 2=HALT.

Behaviour:
- Reset (async assert, sync-released use):
  - pc=RESET_PC, link_addr=0, state=RUN, flush counter=0.
  - fetch_valid=0 while rst_n low; 1 from the first edge after release.
- fetch_valid = (state==RUN) && !stall. Combinational from the registered state and stall.
- RUN, next-PC priority (highest first):
  - halt: state<=HALT, pc holds.
  - jump_en: pc<=jump_addr; if link_en, link_addr<=pc_plus1; state<=FLUSH; counter<=FLUSH_CYCLES-1.
  - branch_en: pc<=pc_plus1+branch_off (modulo 2^PC_W, carry discarded); state<=FLUSH; counter<=FLUSH_CYCLES-1.
  - stall: everything holds.
  - otherwise: pc<=pc_plus1.
- Stall does not override halt, jump or branch. Redirect inputs are qualified by the current instruction, so they take effect even when stall=1.
- FLUSH:
  - pc holds; jump_en, branch_en and link_en are ignored (they belong to squashed instructions).
  - halt is still honoured: state<=HALT.
  - Counter decrements each non-stalled cycle and freezes under stall.
  - When counter==0 and !stall, state<=RUN.
  - FLUSH_CYCLES=1 gives exactly one bubble: redirect at edge N, fetch_valid=0 during cycle N+1, target issued in cycle N+2.
- HALT:
  - All inputs ignored; pc, link_addr and fetch_valid=0 held until rst_n low.
- Wrap-around:
  - pc 8'hFF increments to 8'h00.
  - A branch target overflow wraps silently; no error flag.
- Simultaneous jump_en and branch_en: jump wins, branch dropped.
- link_en without jump_en has no effect.
- Reset asserted mid-FLUSH or in HALT returns to the reset state immediately, without waiting for a clock.

Decomposition:
- Shared package mips8_pkg:
  - PC_W and RESET_PC defaults.
  - State encoding constants ST_RUN=2'd0, ST_FLUSH=2'd1, ST_HALT=2'd2.
- One natural combinational sub-module, next_pc_mux:
  - Inputs: pc, jump_addr, branch_off and the selects.
  - Outputs: pc_plus1 and the branch target.
- FSM, counter and registers remain in pc_sequencer.

Test Plan:
- Reset then 4 free-running cycles -> pc 00,01,02,03,04; fetch_valid=1 throughout after the first edge.
- At pc=05, jump_en=1, jump_addr=8'h40, link_en=1 -> next edge: pc=40, link_addr=06, state=FLUSH, fetch_valid=0 for exactly one cycle; then pc 40 issued, 41 following.
- At pc=10, branch_en=1, branch_off=8'hFB (-5) -> pc=0C; with branch_off=8'h7F at pc=F0 -> pc=70 (wrap); jump_en asserted during the FLUSH bubble is ignored.
- Free-run from pc=FE -> FF then 00; stall held 3 cycles at pc=22 -> pc stays 22, fetch_valid=0; stall asserted during FLUSH extends the bubble by 3 cycles.
- Simultaneous jump_en (addr 80) and branch_en at pc=30 -> pc=80; halt at pc=81 -> state=HALT, pc frozen at 81, fetch_valid=0 regardless of jump_en.
- Assert rst_n low asynchronously mid-HALT and mid-FLUSH -> pc=00 and state=RUN without waiting for a clock edge.

Source files
------------

// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit MIPS datapath: widths, reset PC and
// program-counter sequencer state encoding.
package mips8_pkg;

    localparam int          PC_W_DEF     = 8;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

    // Bubble counter load value: the counter counts down to zero, so N bubbles load N-1.
    function automatic logic [1:0] flush_init(input int cycles);
        logic [1:0] val_s;
        if (cycles <= 1) begin
            val_s = 2'd0;
        end else if (cycles >= 3) begin
            val_s = 2'd2;
        end else begin
            val_s = 2'(cycles - 1);
        end
        return val_s;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC arithmetic: sequential successor and redirect target (jump or
// PC-relative branch, both modulo 2^PC_W).
module next_pc_mux
    import mips8_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] jump_addr,
    input  logic [PC_W-1:0] branch_off,
    input  logic            jump_sel,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] redirect_pc
);

    logic [PC_W-1:0] branch_target_s;

    assign pc_plus1        = pc + {{(PC_W-1){1'b0}}, 1'b1};
    // Two's-complement offset added as unsigned; the carry out is dropped on purpose.
    assign branch_target_s = pc_plus1 + branch_off;

    // Jump has priority over branch when both are requested.
    always_comb begin
        redirect_pc = branch_target_s;
        if (jump_sel) begin
            redirect_pc = jump_addr;
        end else begin
            redirect_pc = branch_target_s;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, steps/redirects it, inserts flush
// bubbles after redirects, captures link addresses and supports a sticky halt.
module pc_sequencer
    import mips8_pkg::*;
#(
    parameter int              PC_W         = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEF,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            link_en,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_off,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            fetch_valid,
    output logic [PC_W-1:0] link_addr,
    output logic [1:0]      state
);

    localparam logic [1:0] FLUSH_LOAD = flush_init(FLUSH_CYCLES);

    seq_state_t      state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] link_r;
    logic [1:0]      cnt_r;
    logic            live_r;
    logic [PC_W-1:0] pc_plus1_s;
    logic [PC_W-1:0] redirect_pc_s;

    next_pc_mux #(
        .PC_W (PC_W)
    ) u_next_pc_mux (
        .pc          (pc_r),
        .jump_addr   (jump_addr),
        .branch_off  (branch_off),
        .jump_sel    (jump_en),
        .pc_plus1    (pc_plus1_s),
        .redirect_pc (redirect_pc_s)
    );

    // Sequencer FSM with PC, link register and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            link_r  <= '0;
            cnt_r   <= 2'd0;
            live_r  <= 1'b0;
        end else begin
            live_r <= 1'b1;
            case (state_r)
                ST_RUN: begin
                    if (halt) begin
                        state_r <= ST_HALT;
                    end else if (jump_en || branch_en) begin
                        pc_r    <= redirect_pc_s;
                        state_r <= ST_FLUSH;
                        cnt_r   <= FLUSH_LOAD;
                        if (jump_en && link_en) begin
                            link_r <= pc_plus1_s;
                        end else begin
                            link_r <= link_r;
                        end
                    end else if (!stall) begin
                        pc_r <= pc_plus1_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                // Redirect requests here come from squashed instructions and are dropped.
                ST_FLUSH: begin
                    if (halt) begin
                        state_r <= ST_HALT;
                    end else if (!stall) begin
                        if (cnt_r == 2'd0) begin
                            state_r <= ST_RUN;
                        end else begin
                            cnt_r <= cnt_r - 2'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_HALT;
                end
            endcase
        end
    end

    assign pc          = pc_r;
    assign pc_plus1    = pc_plus1_s;
    assign link_addr   = link_r;
    assign state       = state_r;
    assign fetch_valid = live_r && (state_r == ST_RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, async-reset
// sequences and randomized traffic against a behavioural model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic       link_en = 1'b0;
    logic       branch_en = 1'b0;
    logic [7:0] branch_off = 8'h00;
    logic       halt = 1'b0;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       fetch_valid;
    logic [7:0] link_addr;
    logic [1:0] state;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .link_en     (link_en),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .halt        (halt),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .fetch_valid (fetch_valid),
        .link_addr   (link_addr),
        .state       (state)
    );

    localparam int FC = 1;

    int checks = 0;
    int errors = 0;

    // Behavioural model: PC value, remaining bubbles, halted flag.
    int m_pc;
    int m_link;
    int m_bub;
    bit m_halt;
    bit m_live;

    typedef struct {
        logic       s, j, l, b, h;
        logic [7:0] ja, bo;
        logic [7:0] pc;
        logic       fv;
        logic [1:0] st;
        logic [7:0] lk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, j, l, b, h, input logic [7:0] ja, bo,
                                input logic [7:0] epc, input logic efv,
                                input logic [1:0] est, input logic [7:0] elk);
        vec_t v;
        v.s = s; v.j = j; v.l = l; v.b = b; v.h = h;
        v.ja = ja; v.bo = bo;
        v.pc = epc; v.fv = efv; v.st = est; v.lk = elk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_link = 0; m_bub = 0; m_halt = 1'b0; m_live = 1'b0;
    endtask

    task automatic model_update();
        m_live = 1'b1;
        if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_bub > 0) begin
            if (halt) m_halt = 1'b1;
            else if (!stall) m_bub = m_bub - 1;
        end else if (halt) begin
            m_halt = 1'b1;
        end else if (jump_en) begin
            if (link_en) m_link = (m_pc + 1) % 256;
            m_pc = int'(jump_addr);
            m_bub = FC;
        end else if (branch_en) begin
            m_pc = (m_pc + 1 + int'(branch_off)) % 256;
            m_bub = FC;
        end else if (!stall) begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic check_model(input string tag);
        int exp_fv;
        int exp_st;
        exp_fv = (m_live && !m_halt && m_bub == 0 && !stall) ? 1 : 0;
        exp_st = m_halt ? 2 : ((m_bub > 0) ? 1 : 0);
        chk({tag, "_pc"}, 32'(pc), m_pc);
        chk({tag, "_pc_plus1"}, 32'(pc_plus1), (m_pc + 1) % 256);
        chk({tag, "_fetch_valid"}, 32'(fetch_valid), exp_fv);
        chk({tag, "_state"}, 32'(state), exp_st);
        chk({tag, "_link"}, 32'(link_addr), m_link);
    endtask

    task automatic drive(input logic s, j, l, b, h, input logic [7:0] ja, bo);
        stall = s; jump_en = j; link_en = l; branch_en = b; halt = h;
        jump_addr = ja; branch_off = bo;
    endtask

    task automatic clock();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        chk({tag, "_const_pc"}, 32'(pc), 32'h0);
        chk({tag, "_const_state"}, 32'(state), 32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int halt_cnt;
        // Columns: stall jump link branch halt jaddr boff | pc fv state link (this cycle)
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 8'h00));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h01, 1, 2'd0, 8'h00));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h02, 1, 2'd0, 8'h00));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h03, 1, 2'd0, 8'h00));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h04, 1, 2'd0, 8'h00));
        tbl.push_back(mk(0,1,1,0,0, 8'h40, 8'h00, 8'h05, 1, 2'd0, 8'h00));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h40, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,0,1,0,0, 8'h00, 8'h00, 8'h40, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,1,0,0,0, 8'h10, 8'h00, 8'h41, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h10, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,0,0,1,0, 8'h00, 8'hFB, 8'h10, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,1,1,1,0, 8'h77, 8'h05, 8'h0C, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,1,0,0,0, 8'hF0, 8'h00, 8'h0C, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'hF0, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,0,0,1,0, 8'h00, 8'h7F, 8'hF0, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h70, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,1,0,0,0, 8'hFE, 8'h00, 8'h70, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'hFE, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'hFE, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'hFF, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,1,0,0,0, 8'h22, 8'h00, 8'h00, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h22, 0, 2'd1, 8'h06));
        tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h22, 0, 2'd0, 8'h06));
        tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h22, 0, 2'd0, 8'h06));
        tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h22, 0, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h22, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,1,0, 8'h00, 8'h00, 8'h23, 1, 2'd0, 8'h06));
        tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h24, 0, 2'd1, 8'h06));
        tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h24, 0, 2'd1, 8'h06));
        tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h24, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h24, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,1,0,0,0, 8'h30, 8'h00, 8'h24, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h30, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,1,0,1,0, 8'h80, 8'h10, 8'h30, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h80, 0, 2'd1, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h80, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h00, 8'h81, 1, 2'd0, 8'h06));
        tbl.push_back(mk(0,1,1,1,0, 8'h55, 8'h05, 8'h81, 0, 2'd2, 8'h06));
        tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 8'h81, 0, 2'd2, 8'h06));

        // Reset state while rst_n is held low.
        model_reset();
        #3;
        check_model("reset");
        chk("reset_fetch_valid", 32'(fetch_valid), 32'h0);
        #3;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].j, tbl[i].l, tbl[i].b, tbl[i].h, tbl[i].ja, tbl[i].bo);
            #1;
            check_model($sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_fv", i), 32'(fetch_valid), 32'(tbl[i].fv));
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_link", i), 32'(link_addr), 32'(tbl[i].lk));
            clock();
        end

        // Async reset while halted, then again in the middle of a flush bubble.
        async_reset("rst_in_halt");
        drive(0,0,0,0,0, 8'h00, 8'h00);
        #1; check_model("post_rst0"); clock();
        drive(0,1,0,0,0, 8'h40, 8'h00);
        #1; check_model("post_rst1"); clock();
        drive(0,0,0,0,0, 8'h00, 8'h00);
        #1;
        chk("pre_flush_rst_state", 32'(state), 32'h1);
        async_reset("rst_in_flush");
        drive(0,0,0,0,0, 8'h00, 8'h00);
        #1; check_model("post_rst2"); clock();

        // Randomized traffic against the model.
        halt_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 3 || halt_cnt > 8) begin
                async_reset($sformatf("rnd%0d_rst", n));
                halt_cnt = 0;
            end
            drive($urandom_range(99) < 25, $urandom_range(99) < 12, $urandom_range(1),
                  $urandom_range(99) < 15, $urandom_range(99) < 2,
                  8'($urandom_range(255)), 8'($urandom_range(255)));
            #1;
            check_model($sformatf("rnd%0d", n));
            clock();
            if (m_halt) halt_cnt++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
